// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 RGB444 capture path.
// Pixels are packed as {R[3:0], G[3:0], B[3:0]}.
package ov7670_pkg;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } cap_state_t;

  typedef logic [11:0] pixel_t;

  // Nibble positions inside the packed pixel
  localparam int PIX_R_MSB = 11;
  localparam int PIX_R_LSB = 8;
  localparam int PIX_G_MSB = 7;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_MSB = 3;
  localparam int PIX_B_LSB = 0;

  // The first camera byte carries R in its low nibble; the second byte is {G, B}
  localparam int CAM_R_MSB = 3;
  localparam int CAM_R_LSB = 0;

  function automatic pixel_t pack_rgb444(input logic [3:0] r, input logic [7:0] gb);
    pixel_t p;
    p = '0;
    p[PIX_R_MSB:PIX_R_LSB] = r;
    p[PIX_G_MSB:PIX_B_LSB] = gb;
    return p;
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port of the capture block, plus the FSM state for observation.
// w_en qualifies w_addr/w_data for exactly one pclk cycle; there is no ready, so the sink accepts every strobe.
interface ov7670_capture_if #(
  parameter int AW = 20
);
  import ov7670_pkg::*;

  logic [AW-1:0] w_addr;
  pixel_t        w_data;
  logic          w_en;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          line_err;
  cap_state_t    state;

  modport master (
    output w_addr, w_data, w_en, frame_done, frame_count, line_err, state
  );

  modport slave (
    input w_addr, w_data, w_en, frame_done, frame_count, line_err, state
  );

endinterface

// File: rtl/ov7670_sync_edge.sv
// Registers the camera bus once and detects VSYNC rise / HREF fall on the registered copies.
module ov7670_sync_edge (
  input  logic       pclk,
  input  logic       rst,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vs_rise,
  output logic       href_fall,
  output logic       href_r,
  output logic [7:0] data_r
);

  logic vs_r;
  logic vs_q;
  logic href_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_r   <= 1'b0;
      vs_q   <= 1'b0;
      href_r <= 1'b0;
      href_q <= 1'b0;
      data_r <= '0;
    end else begin
      vs_r   <= cam_vsync;
      vs_q   <= vs_r;
      href_r <= cam_href;
      href_q <= href_r;
      data_r <= cam_data;
    end
  end

  assign vs_rise   = vs_r & ~vs_q;
  assign href_fall = ~href_r & href_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: packs byte pairs into 12-bit pixels and writes them linearly
// into the frame buffer, skipping start-up frames and flagging malformed lines/frames.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int SKIP_FRAMES       = 2,
  localparam int AW = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT) + 1
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  input  logic       enable,
  ov7670_capture_if.master wr
);

  localparam int XW = $clog2(RESOLUTION_WIDTH + 1);
  localparam int YW = $clog2(RESOLUTION_HEIGHT + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(RESOLUTION_WIDTH);
  localparam logic [YW-1:0] Y_MAX = YW'(RESOLUTION_HEIGHT);
  localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP_FRAMES);

  logic       vs_rise;
  logic       href_fall;
  logic       href_r;
  logic [7:0] data_r;

  ov7670_sync_edge u_sync (
    .pclk      (pclk),
    .rst       (rst),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .vs_rise   (vs_rise),
    .href_fall (href_fall),
    .href_r    (href_r),
    .data_r    (data_r)
  );

  cap_state_t    state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          phase_q, phase_d;
  logic [3:0]    r_q, r_d;
  logic [AW-1:0] addr_q, addr_d;
  pixel_t        data_q, data_d;
  logic          wen_q, wen_d;
  logic          fd_q, fd_d;
  logic [7:0]    fc_q, fc_d;
  logic          err_q, err_d;
  logic          start;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_VS;
      skip_q  <= SKIP_INIT;
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      r_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      fd_q    <= 1'b0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      fd_q    <= fd_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    r_d     = r_q;
    // The address advances on the edge after each write, so it is held while w_en is high
    addr_d  = wen_q ? addr_q + 1'b1 : addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    fd_d    = 1'b0;
    fc_d    = fc_q;
    err_d   = err_q;
    start   = 1'b0;

    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          if (skip_q != '0) skip_d = skip_q - 1'b1;
          else if (enable)  start  = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          fd_d = 1'b1;
          fc_d = fc_q + 8'd1;
          if (y_q != Y_MAX) err_d = 1'b1;
          if (enable) start   = 1'b1;
          else        state_d = WAIT_VS;
        end else if (href_fall) begin
          phase_d = 1'b0;
          if (phase_q || (x_q != X_MAX)) err_d = 1'b1;
          x_d = '0;
          if (y_q != Y_MAX) y_d = y_q + 1'b1;
        end else if (href_r) begin
          if (!phase_q) begin
            r_d     = data_r[CAM_R_MSB:CAM_R_LSB];
            phase_d = 1'b1;
          end else begin
            data_d  = pack_rgb444(r_q, data_r);
            phase_d = 1'b0;
            // Pixels outside the active window are dropped and flagged
            if ((x_q < X_MAX) && (y_q < Y_MAX)) wen_d = 1'b1;
            else                                err_d = 1'b1;
            if (x_q != X_MAX) x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase

    if (start) begin
      state_d = ACTIVE;
      addr_d  = '0;
      x_d     = '0;
      y_d     = '0;
      phase_d = 1'b0;
    end
  end

  assign wr.w_addr      = addr_q;
  assign wr.w_data      = data_q;
  assign wr.w_en        = wen_q;
  assign wr.frame_done  = fd_q;
  assign wr.frame_count = fc_q;
  assign wr.line_err    = err_q;
  assign wr.state       = state_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture with a small 4x2 frame and two skipped frames.
module tb_ov7670_capture;
  import ov7670_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int SKIP = 2;
  localparam int AW   = $clog2(W * H) + 1;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       enable = 1'b1;

  ov7670_capture_if #(.AW(AW)) wr_if ();

  ov7670_capture #(
    .RESOLUTION_WIDTH  (W),
    .RESOLUTION_HEIGHT (H),
    .SKIP_FRAMES       (SKIP)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .enable    (enable),
    .wr        (wr_if)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  // scoreboard
  logic [AW+11:0] exp_q[$];
  logic [7:0]     fd_q[$];
  logic [AW+11:0] exp_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input logic [11:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  // monitor
  always @(negedge pclk) begin
    if (wr_if.w_en) begin
      chk("addr_in_range", 32'(int'(wr_if.w_addr) < W * H), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 wr_if.w_addr, wr_if.w_data);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_if.w_addr), 32'(exp_e[AW+11:12]));
        chk("wr_data", 32'(wr_if.w_data), 32'(exp_e[11:0]));
      end
    end
    if (wr_if.frame_done) begin
      if (fd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame_done: got frame_count %0d, expected no pulse",
                 wr_if.frame_count);
      end else begin
        chk("frame_count_at_done", 32'(wr_if.frame_count), 32'(fd_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic vsync_pulse();
    @(negedge pclk);
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    cyc(3);
    cam_vsync = 1'b0;
    cyc(3);
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2);
    @(negedge pclk);
    cam_href = 1'b1;
    cam_data = b1;
    @(negedge pclk);
    cam_data = b2;
  endtask

  task automatic end_line();
    @(negedge pclk);
    cam_href = 1'b0;
    cam_data = 8'($urandom_range(0, 255));
    cyc(3);
  endtask

  // pixel p of a line tagged t carries R=t+p, G=p, B=t; the high nibble of byte 1 is junk
  task automatic send_pixels(input int base, input int n, input bit push, input logic [3:0] tag);
    for (int p = 0; p < n; p++) begin
      logic [3:0] r;
      logic [3:0] pn;
      r  = tag + 4'(p);
      pn = 4'(p);
      if (push && p < W) push_exp(base + p, {r, pn, tag});
      send_pixel({4'hC, r}, {pn, tag});
    end
  endtask

  task automatic send_line(input int base, input int n, input bit push, input logic [3:0] tag);
    send_pixels(base, n, push, tag);
    end_line();
  endtask

  task automatic send_frame(input bit push, input logic [3:0] tag);
    for (int l = 0; l < H; l++) send_line(l * W, W, push, tag + 4'(l));
  endtask

  task automatic check_idle(input string name);
    chk(name, 32'({wr_if.w_addr, wr_if.w_data, wr_if.w_en, wr_if.frame_done,
                   wr_if.frame_count, wr_if.line_err}), 32'd0);
    chk({name, "_state"}, 32'(wr_if.state), 32'(WAIT_VS));
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst       = 1'b1;
    cam_href  = 1'b0;
    cam_vsync = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    // reset held with random bus activity
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      if (i >= 2 && (i % 3) == 0) check_idle("reset_idle");
      cam_vsync = 1'($urandom_range(0, 1));
      cam_href  = 1'($urandom_range(0, 1));
      cam_data  = 8'($urandom_range(0, 255));
    end
    @(negedge pclk);
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check_idle("after_reset");

    // two skipped frames, then frame 3 written at 0..7
    vsync_pulse(); send_frame(1'b0, 4'd1);
    vsync_pulse(); send_frame(1'b0, 4'd2);
    vsync_pulse(); send_frame(1'b1, 4'd3);
    chk("frame3_err", 32'(wr_if.line_err), 32'd0);
    chk("frame3_fc_before_done", 32'(wr_if.frame_count), 32'd0);
    chk("frame3_all_written", 32'(exp_q.size()), 32'd0);
    fd_q.push_back(8'd1);
    vsync_pulse();
    chk("frame3_fc_after_done", 32'(wr_if.frame_count), 32'd1);
    chk("frame3_state_active", 32'(wr_if.state), 32'(ACTIVE));

    // packing and latency: 0x0A,0xBC -> 0xABC @0 ; 0x05,0x67 -> 0x567 @1
    push_exp(0, 12'hABC);
    push_exp(1, 12'h567);
    push_exp(2, 12'h123);
    push_exp(3, 12'hFED);
    @(negedge pclk); cam_href = 1'b1; cam_data = 8'h0A;
    @(negedge pclk); cam_data = 8'hBC;
    @(negedge pclk);
    chk("lat_not_yet", 32'(wr_if.w_en), 32'd0);
    cam_data = 8'h05;
    @(negedge pclk);
    chk("lat_wen", 32'(wr_if.w_en), 32'd1);
    chk("lat_addr", 32'(wr_if.w_addr), 32'd0);
    chk("lat_data", 32'(wr_if.w_data), 32'hABC);
    cam_data = 8'h67;
    @(negedge pclk);
    chk("wen_one_cycle", 32'(wr_if.w_en), 32'd0);
    cam_data = 8'h01;
    @(negedge pclk);
    chk("second_addr", 32'(wr_if.w_addr), 32'd1);
    chk("second_data", 32'(wr_if.w_data), 32'h567);
    cam_data = 8'h23;
    send_pixel(8'h0F, 8'hED);
    end_line();
    send_line(4, 4, 1'b1, 4'd5);
    chk("pack_err", 32'(wr_if.line_err), 32'd0);
    fd_q.push_back(8'd2);
    vsync_pulse();

    // long line: 5 pixels, only 4 written
    send_line(0, 5, 1'b1, 4'd6);
    chk("long_line_err", 32'(wr_if.line_err), 32'd1);
    chk("long_line_drained", 32'(exp_q.size()), 32'd0);

    // odd line: 9 bytes after reset
    do_reset();
    check_idle("odd_reset");
    vsync_pulse(); vsync_pulse(); vsync_pulse();
    send_pixels(0, 4, 1'b1, 4'd7);
    @(negedge pclk); cam_data = 8'h0E;
    cyc(2);
    chk("odd_err_before_fall", 32'(wr_if.line_err), 32'd0);
    end_line();
    chk("odd_line_err", 32'(wr_if.line_err), 32'd1);

    // early vsync after 1 of 2 lines
    do_reset();
    vsync_pulse(); vsync_pulse(); vsync_pulse();
    send_line(0, 4, 1'b1, 4'd8);
    chk("early_err_before", 32'(wr_if.line_err), 32'd0);
    fd_q.push_back(8'd1);
    vsync_pulse();
    chk("early_err_after", 32'(wr_if.line_err), 32'd1);
    send_line(0, 4, 1'b1, 4'd9);

    // reset between the two bytes of pixel 3
    send_pixels(4, 2, 1'b1, 4'd10);
    @(negedge pclk); cam_data = 8'h03;
    @(negedge pclk);
    #2 rst = 1'b1;
    #1 check_idle("midline_reset");
    cam_href = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("midline_drained", 32'(exp_q.size()), 32'd0);
    vsync_pulse(); send_frame(1'b0, 4'd11);
    vsync_pulse(); send_frame(1'b0, 4'd12);
    vsync_pulse();
    send_line(0, 4, 1'b1, 4'd13);

    // enable dropped mid-frame: frame ends, then capture idles
    enable = 1'b0;
    send_line(4, 4, 1'b1, 4'd14);
    fd_q.push_back(8'd1);
    vsync_pulse();
    chk("disabled_state", 32'(wr_if.state), 32'(WAIT_VS));
    send_line(0, 4, 1'b0, 4'd15);
    vsync_pulse();

    cyc(5);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_fd_empty", 32'(fd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
